// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the tagged-word memory arbiter.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_WIDTH = 8;
    localparam int WORD_WIDTH     = 16;
    localparam int MEMORY_SIZE    = 256;
    localparam int NUM_REQ        = 3;
    localparam int LOCK_TIMEOUT   = 64;

    // Requester indices; lower index is not inherently higher priority.
    localparam int REQ_EVAL  = 0;
    localparam int REQ_ALLOC = 1;
    localparam int REQ_DEBUG = 2;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Width of an index into n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter.
//
// Handshake: a request is accepted in the cycle where req_valid[i] and
// req_ready[i] are both high. While valid is high and ready is low the
// requester keeps addr/we/wdata/lock stable. req_ready is at most one-hot.
// A read accepted in cycle N returns resp_valid[i] with resp_rdata in
// cycle N+1; writes return nothing.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int NumReq    = NUM_REQ,
    parameter int AddrWidth = MEM_ADDR_WIDTH,
    parameter int DataWidth = WORD_WIDTH
) ();

    logic [NumReq-1:0]           req_valid;
    logic [NumReq-1:0]           req_ready;
    logic [NumReq-1:0]           req_we;
    logic [NumReq-1:0]           req_lock;
    logic [NumReq*AddrWidth-1:0] req_addr;
    logic [NumReq*DataWidth-1:0] req_wdata;
    logic [NumReq-1:0]           resp_valid;
    logic [DataWidth-1:0]        resp_rdata;

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: first set request bit searching upward from ptr+1.
module mem_arbiter_rr_picker
    import mem_arbiter_pkg::*;
#(
    parameter int  NumReq   = NUM_REQ,
    localparam int IdxWidth = idx_width(NumReq)
) (
    input  logic [NumReq-1:0]   req,
    input  logic [IdxWidth-1:0] ptr,
    output logic [NumReq-1:0]   grant,
    output logic [IdxWidth-1:0] grant_idx,
    output logic                grant_any
);

    // Scan NumReq candidates starting just after the last winner
    always_comb begin
        int cand;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int i = 1; i <= NumReq; i++) begin
            cand = (int'(ptr) + i) % NumReq;
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IdxWidth'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between
// requesters, with a bus lock for atomic multi-word sequences and a
// watchdog that releases a lock whose owner stops issuing requests.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NumReq      = NUM_REQ,
    parameter int AddrWidth   = MEM_ADDR_WIDTH,
    parameter int DataWidth   = WORD_WIDTH,
    parameter int MemDepth    = MEMORY_SIZE,
    parameter int LockTimeout = LOCK_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_arbiter_if.slave         bus,
    output logic                 addr_error,
    output logic                 lock_timeout,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic [DataWidth-1:0] mem_rdata,
    output arb_state_t           dbg_state
);

    localparam int IdxWidth = idx_width(NumReq);
    localparam int CntWidth = $clog2(LockTimeout + 1);
    localparam logic [IdxWidth-1:0]  PtrReset   = IdxWidth'(NumReq - 1);
    localparam logic [AddrWidth:0]   DepthLimit = (AddrWidth + 1)'(MemDepth);
    localparam logic [CntWidth-1:0]  CntLast    = CntWidth'(LockTimeout - 1);

    arb_state_t          state_q, state_d;
    logic [IdxWidth-1:0] owner_q, owner_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [IdxWidth-1:0] ptr_q, ptr_d;
    logic                resp_pend_q, resp_pend_d;
    logic [IdxWidth-1:0] resp_idx_q, resp_idx_d;
    logic                resp_oor_q, resp_oor_d;
    logic                addr_err_q, addr_err_d;
    logic                timeout_q, timeout_d;

    logic [NumReq-1:0]    eligible;
    logic [NumReq-1:0]    grant;
    logic [IdxWidth-1:0]  grant_idx;
    logic                 fire;
    logic [AddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0] sel_wdata;
    logic                 sel_we;
    logic                 sel_lock;
    logic                 in_range;
    logic                 owner_valid;

    // While locked only the owner may compete; otherwise everyone does
    always_comb begin
        eligible = bus.req_valid;
        if (state_q == ARB_LOCKED) begin
            eligible = bus.req_valid & (NumReq'(1) << owner_q);
        end
    end

    mem_arbiter_rr_picker #(.NumReq(NumReq)) u_picker (
        .req       (eligible),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (fire)
    );

    // Fields of the granted request and the address range check
    always_comb begin
        sel_addr    = bus.req_addr[int'(grant_idx) * AddrWidth +: AddrWidth];
        sel_wdata   = bus.req_wdata[int'(grant_idx) * DataWidth +: DataWidth];
        sel_we      = bus.req_we[grant_idx];
        sel_lock    = bus.req_lock[grant_idx];
        in_range    = {1'b0, sel_addr} < DepthLimit;
        owner_valid = bus.req_valid[owner_q];
    end

    // State register: lock FSM, RR pointer, watchdog and response pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_OPEN;
            owner_q     <= '0;
            cnt_q       <= '0;
            ptr_q       <= PtrReset;
            resp_pend_q <= 1'b0;
            resp_idx_q  <= '0;
            resp_oor_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            resp_pend_q <= resp_pend_d;
            resp_idx_q  <= resp_idx_d;
            resp_oor_q  <= resp_oor_d;
            addr_err_q  <= addr_err_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next state: lock acquire/release, idle watchdog, pointer and read tracking
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        timeout_d   = 1'b0;
        resp_pend_d = fire & ~sel_we;
        resp_idx_d  = grant_idx;
        resp_oor_d  = ~in_range;
        addr_err_d  = fire & ~in_range;
        if (fire) begin
            ptr_d = grant_idx;
        end
        case (state_q)
            ARB_OPEN: begin
                if (fire && sel_lock) begin
                    state_d = ARB_LOCKED;
                    owner_d = grant_idx;
                    cnt_d   = '0;
                end
            end
            ARB_LOCKED: begin
                // In this state a grant can only belong to the owner
                if (fire) begin
                    cnt_d = '0;
                    if (!sel_lock) begin
                        state_d = ARB_OPEN;
                    end
                end else if (!owner_valid) begin
                    if (cnt_q == CntLast) begin
                        state_d   = ARB_OPEN;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_OPEN;
        endcase
    end

    // Outputs: grant, memory port, read return path and status pulses
    always_comb begin
        bus.req_ready  = grant;
        mem_en         = fire & in_range;
        mem_we         = mem_en & sel_we;
        mem_addr       = mem_en ? sel_addr : '0;
        mem_wdata      = mem_we ? sel_wdata : '0;
        bus.resp_valid = resp_pend_q ? (NumReq'(1) << resp_idx_q) : '0;
        bus.resp_rdata = (resp_pend_q && !resp_oor_q) ? mem_rdata : '0;
        addr_error     = addr_err_q;
        lock_timeout   = timeout_q;
        dbg_state      = state_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NR    = 3;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 200;
    localparam int TMO   = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NumReq(NR), .AddrWidth(AW), .DataWidth(DW)) bus ();

    logic          addr_error, lock_timeout, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    arb_state_t    dbg_state;

    mem_arbiter #(
        .NumReq(NR), .AddrWidth(AW), .DataWidth(DW),
        .MemDepth(DEPTH), .LockTimeout(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .addr_error   (addr_error),
        .lock_timeout (lock_timeout),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .dbg_state    (dbg_state)
    );

    // ---------------- memory behind the arbiter ----------------
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] mem [256];
    logic          load = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // ---------------- stimulus state ----------------
    logic          v  [NR];
    logic          we [NR];
    logic          lk [NR];
    logic [AW-1:0] ad [NR];
    logic [DW-1:0] wd [NR];

    // ---------------- reference model ----------------
    int            m_ptr, m_owner, m_idle, m_ridx, m_g;
    bit            m_rv, m_aerr, m_tmo;
    logic [DW-1:0] m_rdata;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_ptr   = NR - 1;
        m_owner = -1;
        m_idle  = 0;
        m_rv    = 0;
        m_ridx  = 0;
        m_aerr  = 0;
        m_tmo   = 0;
        m_g     = -1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]           = v[i];
            bus.req_we[i]              = we[i];
            bus.req_lock[i]            = lk[i];
            bus.req_addr[i*AW +: AW]   = ad[i];
            bus.req_wdata[i*DW +: DW]  = wd[i];
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < NR; i++) begin
            v[i] = 0; we[i] = 0; lk[i] = 0; ad[i] = '0; wd[i] = '0;
        end
        apply();
    endtask

    task automatic set_req(input int i, input bit w, input bit l,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        v[i] = 1; we[i] = w; lk[i] = l; ad[i] = a; wd[i] = d;
        apply();
    endtask

    // At the falling edge: compare every output with the model, then
    // advance the model by the transaction the rising edge will commit.
    task automatic step();
        int g, c;
        bit inr, gwe, glk;
        @(negedge clk);
        g = -1;
        if (m_owner >= 0) begin
            if (v[m_owner]) g = m_owner;
        end else begin
            for (int k = 1; k <= NR; k++) begin
                c = (m_ptr + k) % NR;
                if (g < 0 && v[c]) g = c;
            end
        end
        inr = 0; gwe = 0; glk = 0;
        if (g >= 0) begin
            inr = int'(ad[g]) < DEPTH;
            gwe = we[g];
            glk = lk[g];
        end
        chk("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("mem_en", 32'(mem_en), 32'(inr));
        chk("mem_we", 32'(mem_we), 32'(inr && gwe));
        if (inr) begin
            chk("mem_addr", 32'(mem_addr), 32'(ad[g]));
            if (gwe) chk("mem_wdata", 32'(mem_wdata), 32'(wd[g]));
        end
        chk("resp_valid", 32'(bus.resp_valid), m_rv ? (32'd1 << m_ridx) : 32'd0);
        if (m_rv) chk("resp_rdata", 32'(bus.resp_rdata), 32'(m_rdata));
        chk("addr_error", 32'(addr_error), 32'(m_aerr));
        chk("lock_timeout", 32'(lock_timeout), 32'(m_tmo));
        chk("locked", 32'(dbg_state == ARB_LOCKED), 32'(m_owner >= 0));

        if (!rst) begin
            m_reset();
            return;
        end
        m_rv    = (g >= 0) && !gwe;
        m_ridx  = (g >= 0) ? g : 0;
        m_rdata = inr ? ref_mem[ad[g]] : '0;
        m_aerr  = (g >= 0) && !inr;
        m_tmo   = 0;
        if (inr && gwe) ref_mem[ad[g]] = wd[g];
        if (g >= 0) m_ptr = g;
        if (m_owner < 0) begin
            if (g >= 0 && glk) begin
                m_owner = g;
                m_idle  = 0;
            end
        end else if (g >= 0) begin
            m_idle = 0;
            if (!glk) m_owner = -1;
        end else if (!v[m_owner]) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_owner = -1;
                m_idle  = 0;
                m_tmo   = 1;
            end
        end
        m_g = g;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        step();
        adv();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        clear_all();
        m_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'($urandom);
        ref_mem[4] = 16'h789A;
        load = 1'b1;
        cyc();
        load = 1'b0;
        cyc();
        rst = 1'b1;

        // 1: all three read addr 4 -> grants 0,1,2, responses one cycle later
        for (int i = 0; i < NR; i++) set_req(i, 0, 0, 8'h04, '0);
        step(); chk("t1_grant_eval", 32'(bus.req_ready), 32'b001); adv();
        step(); chk("t1_grant_alloc", 32'(bus.req_ready), 32'b010);
        chk("t1_resp_eval", 32'(bus.resp_valid), 32'b001);
        chk("t1_rdata_eval", 32'(bus.resp_rdata), 32'h789A); adv();
        step(); chk("t1_grant_debug", 32'(bus.req_ready), 32'b100);
        chk("t1_resp_alloc", 32'(bus.resp_valid), 32'b010);
        chk("t1_rdata_alloc", 32'(bus.resp_rdata), 32'h789A); adv();
        clear_all();
        step(); chk("t1_resp_debug", 32'(bus.resp_valid), 32'b100);
        chk("t1_rdata_debug", 32'(bus.resp_rdata), 32'h789A); adv();

        // 2: allocator writes 0x10, evaluator reads it back
        set_req(REQ_ALLOC, 1, 0, 8'h10, 16'h1234);
        step(); chk("t2_wr_grant", 32'(bus.req_ready), 32'b010); adv();
        clear_all();
        set_req(REQ_EVAL, 0, 0, 8'h10, '0);
        step(); chk("t2_no_wr_resp", 32'(bus.resp_valid), 32'b000); adv();
        clear_all();
        step(); chk("t2_rd_resp", 32'(bus.resp_valid), 32'b001);
        chk("t2_rd_data", 32'(bus.resp_rdata), 32'h1234); adv();

        // 3: allocator locked sequence while the evaluator keeps asking
        set_req(REQ_EVAL, 0, 0, 8'h20, '0);
        set_req(REQ_ALLOC, 0, 1, 8'h01, '0);
        step(); chk("t3_lock_rd", 32'(bus.req_ready), 32'b010); adv();
        set_req(REQ_ALLOC, 1, 1, 8'h02, 16'hA5A5);
        step(); chk("t3_locked_wr", 32'(bus.req_ready), 32'b010);
        chk("t3_state_locked", 32'(dbg_state), 32'(ARB_LOCKED)); adv();
        set_req(REQ_ALLOC, 1, 0, 8'h03, 16'h5A5A);
        step(); chk("t3_release_wr", 32'(bus.req_ready), 32'b010); adv();
        v[REQ_ALLOC] = 0; apply();
        step(); chk("t3_eval_after", 32'(bus.req_ready), 32'b001); adv();
        clear_all();
        cyc();

        // 4: debug takes the lock and goes idle until the watchdog fires
        set_req(REQ_DEBUG, 0, 1, 8'h05, '0);
        step(); chk("t4_lock_grant", 32'(bus.req_ready), 32'b100); adv();
        v[REQ_DEBUG] = 0;
        set_req(REQ_EVAL, 0, 0, 8'h06, '0);
        for (int k = 0; k < TMO; k++) begin
            step(); chk("t4_blocked", 32'(bus.req_ready), 32'b000); adv();
        end
        step(); chk("t4_timeout_pulse", 32'(lock_timeout), 32'd1);
        chk("t4_eval_granted", 32'(bus.req_ready), 32'b001); adv();
        step(); chk("t4_pulse_once", 32'(lock_timeout), 32'd0); adv();
        clear_all();
        cyc();

        // 5: out-of-range read (addr 200 with a 200-word memory)
        set_req(REQ_ALLOC, 0, 0, 8'hC8, '0);
        step(); chk("t5_accepted", 32'(bus.req_ready), 32'b010);
        chk("t5_mem_en_low", 32'(mem_en), 32'd0); adv();
        clear_all();
        step(); chk("t5_addr_error", 32'(addr_error), 32'd1);
        chk("t5_resp", 32'(bus.resp_valid), 32'b010);
        chk("t5_zero_data", 32'(bus.resp_rdata), 32'h0000); adv();
        step(); chk("t5_error_once", 32'(addr_error), 32'd0); adv();

        // 6: reset right after an accepted read drops its response
        set_req(REQ_EVAL, 0, 0, 8'h07, '0);
        step(); chk("t6_accept", 32'(bus.req_ready), 32'b001); adv();
        rst = 1'b0;
        clear_all();
        m_reset();
        step(); chk("t6_dropped", 32'(bus.resp_valid), 32'b000); adv();
        cyc();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 0, 0, 8'h08, '0);
        step(); chk("t6_first_grant", 32'(bus.req_ready), 32'b001); adv();
        clear_all();
        cyc();

        // Random traffic; a pending request keeps its fields until accepted
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!v[i] || m_g == i) begin
                    v[i]  = ($urandom_range(0, 9) < 6);
                    we[i] = 1'($urandom_range(0, 1));
                    lk[i] = ($urandom_range(0, 5) == 0);
                    ad[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(DEPTH, 255))
                                                        : 8'($urandom_range(0, 31));
                    wd[i] = 16'($urandom);
                end
            end
            apply();
            cyc();
        end
        clear_all();
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
